// File: rtl/age_ordered_issue_queue_if.sv
// Dispatch, wakeup, PRF-read and issue signals of the age-ordered issue queue.
// IQ_STATS_EN adds the stat_issued / stat_full_stall counters.
interface age_ordered_issue_queue_if #(
  parameter int unsigned INST_ID_BITS = 6,
  parameter int unsigned PRN_BITS     = 6,
  parameter int unsigned MAX_OPERANDS = 3,
  parameter int unsigned QUEUE_SIZE   = 8,
  parameter int unsigned WAKE_PORTS   = 12
);
  localparam int unsigned K      = MAX_OPERANDS;
  localparam int unsigned OCC_W  = $clog2(QUEUE_SIZE + 1);

  logic                       in_valid;
  logic                       in_ready;
  logic [INST_ID_BITS-1:0]    in_inst_id;
  logic [31:0]                in_inst;
  logic [63:0]                in_pc;
  logic [K-1:0]               in_op_valid;
  logic [K-1:0]               in_op_ready;
  logic [K*PRN_BITS-1:0]      in_op_prn;
  logic [K*PRN_BITS-1:0]      in_out_prn;
  logic [WAKE_PORTS-1:0]      wake_valid;
  logic [WAKE_PORTS*PRN_BITS-1:0] wake_prn;
  logic                       flush;
  logic [K-1:0]               prf_read_en;
  logic [K*PRN_BITS-1:0]      prf_read_prn;
  logic [K*64-1:0]            prf_op;
  logic                       iss_valid;
  logic                       iss_ready;
  logic [INST_ID_BITS-1:0]    iss_inst_id;
  logic [31:0]                iss_inst;
  logic [63:0]                iss_pc;
  logic [K*PRN_BITS-1:0]      iss_out_prn;
  logic [K*64-1:0]            iss_op;
  logic [OCC_W-1:0]           occupancy;
`ifdef IQ_STATS_EN
  logic [31:0]                stat_issued;
  logic [31:0]                stat_full_stall;

  modport master (
    output in_valid, in_inst_id, in_inst, in_pc, in_op_valid, in_op_ready, in_op_prn, in_out_prn,
           wake_valid, wake_prn, flush, prf_op, iss_ready,
    input  in_ready, prf_read_en, prf_read_prn, iss_valid, iss_inst_id, iss_inst, iss_pc,
           iss_out_prn, iss_op, occupancy, stat_issued, stat_full_stall
  );
  modport slave (
    input  in_valid, in_inst_id, in_inst, in_pc, in_op_valid, in_op_ready, in_op_prn, in_out_prn,
           wake_valid, wake_prn, flush, prf_op, iss_ready,
    output in_ready, prf_read_en, prf_read_prn, iss_valid, iss_inst_id, iss_inst, iss_pc,
           iss_out_prn, iss_op, occupancy, stat_issued, stat_full_stall
  );
`else
  modport master (
    output in_valid, in_inst_id, in_inst, in_pc, in_op_valid, in_op_ready, in_op_prn, in_out_prn,
           wake_valid, wake_prn, flush, prf_op, iss_ready,
    input  in_ready, prf_read_en, prf_read_prn, iss_valid, iss_inst_id, iss_inst, iss_pc,
           iss_out_prn, iss_op, occupancy
  );
  modport slave (
    input  in_valid, in_inst_id, in_inst, in_pc, in_op_valid, in_op_ready, in_op_prn, in_out_prn,
           wake_valid, wake_prn, flush, prf_op, iss_ready,
    output in_ready, prf_read_en, prf_read_prn, iss_valid, iss_inst_id, iss_inst, iss_pc,
           iss_out_prn, iss_op, occupancy
  );
`endif
endinterface

// File: rtl/age_ordered_issue_queue.sv
// Per-FU reservation station: tag wakeup, oldest-ready select via age matrix, registered issue port.
// Optional IQ_STATS_EN adds saturating issued / full-stall counters.
module age_ordered_issue_queue #(
  parameter int unsigned INST_ID_BITS = 6,
  parameter int unsigned PRN_BITS     = 6,
  parameter int unsigned MAX_OPERANDS = 3,
  parameter int unsigned QUEUE_SIZE   = 8,
  parameter int unsigned WAKE_PORTS   = 12,
  parameter int unsigned FU_INDEX     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  age_ordered_issue_queue_if.slave bus
);
  localparam int unsigned N     = QUEUE_SIZE;
  localparam int unsigned K     = MAX_OPERANDS;
  localparam int unsigned P     = PRN_BITS;
  localparam int unsigned W     = WAKE_PORTS;
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned OCC_W = $clog2(N + 1);

  logic [N-1:0]              valid_q;
  logic [N-1:0]              older_q [N];  // older_q[j][i]: entry j is older than entry i
  logic [INST_ID_BITS-1:0]   id_q    [N];
  logic [31:0]               inst_q  [N];
  logic [63:0]               pc_q    [N];
  logic [K-1:0]              opv_q   [N];
  logic [K-1:0]              opr_q   [N];
  logic [K*P-1:0]            prn_q   [N];
  logic [K*P-1:0]            outprn_q[N];
  logic [OCC_W-1:0]          occ_q;

  logic                      iss_valid_q;
  logic [INST_ID_BITS-1:0]   iss_id_q;
  logic [31:0]               iss_inst_q;
  logic [63:0]               iss_pc_q;
  logic [K*P-1:0]            iss_outprn_q;
  logic [K*64-1:0]           iss_op_q;

  logic [N-1:0]              ent_rdy;
  logic [N-1:0]              sel;
  logic                      any_rdy;
  logic                      blk;
  logic [IDX_W-1:0]          sel_idx;
  logic [IDX_W-1:0]          free_idx;
  logic [K-1:0]              wake_set[N];
  logic [K-1:0]              in_wake;
  logic                      issue_fire;
  logic                      insert;

  function automatic logic tag_hit(input logic [P-1:0] tag, input logic [W-1:0] wv,
                                   input logic [W*P-1:0] wp);
    tag_hit = 1'b0;
    for (int w = 0; w < int'(W); w++)
      if (wv[w] && (wp[w*P +: P] == tag)) tag_hit = 1'b1;
  endfunction

  // Readiness, oldest-ready select, free-slot pick and wakeup matches
  always_comb begin
    ent_rdy  = '0;
    sel      = '0;
    blk      = 1'b0;
    sel_idx  = '0;
    free_idx = '0;
    in_wake  = '0;
    for (int i = 0; i < int'(N); i++) begin
      ent_rdy[i]  = valid_q[i] & (&(opr_q[i] | ~opv_q[i]));
      wake_set[i] = '0;
      for (int k = 0; k < int'(K); k++)
        wake_set[i][k] = valid_q[i] & opv_q[i][k] &
                         tag_hit(prn_q[i][k*P +: P], bus.wake_valid, bus.wake_prn);
    end
    for (int i = 0; i < int'(N); i++) begin
      blk = 1'b0;
      for (int j = 0; j < int'(N); j++)
        if (ent_rdy[j] && older_q[j][i]) blk = 1'b1;
      sel[i] = ent_rdy[i] & ~blk;
      if (sel[i]) sel_idx = IDX_W'(i);
    end
    for (int i = int'(N) - 1; i >= 0; i--)
      if (!valid_q[i]) free_idx = IDX_W'(i);
    for (int k = 0; k < int'(K); k++)
      in_wake[k] = tag_hit(bus.in_op_prn[k*P +: P], bus.wake_valid, bus.wake_prn);
  end

  assign any_rdy    = |ent_rdy;
  assign bus.in_ready = (occ_q != OCC_W'(N));
  assign insert     = bus.in_valid & bus.in_ready;
  assign issue_fire = (~iss_valid_q | bus.iss_ready) & any_rdy;

  assign bus.prf_read_en  = any_rdy ? opv_q[sel_idx] : '0;
  assign bus.prf_read_prn = any_rdy ? prn_q[sel_idx] : '0;

  assign bus.iss_valid   = iss_valid_q;
  assign bus.iss_inst_id = iss_id_q;
  assign bus.iss_inst    = iss_inst_q;
  assign bus.iss_pc      = iss_pc_q;
  assign bus.iss_out_prn = iss_outprn_q;
  assign bus.iss_op      = iss_op_q;
  assign bus.occupancy   = occ_q;

  // Entry storage, age matrix and issue register; flush beats insert, issue and wakeup
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      occ_q        <= '0;
      iss_valid_q  <= 1'b0;
      iss_id_q     <= '0;
      iss_inst_q   <= '0;
      iss_pc_q     <= '0;
      iss_outprn_q <= '0;
      iss_op_q     <= '0;
      for (int i = 0; i < int'(N); i++) begin
        older_q[i]  <= '0;
        id_q[i]     <= '0;
        inst_q[i]   <= '0;
        pc_q[i]     <= '0;
        opv_q[i]    <= '0;
        opr_q[i]    <= '0;
        prn_q[i]    <= '0;
        outprn_q[i] <= '0;
      end
    end else if (bus.flush) begin
      valid_q     <= '0;
      occ_q       <= '0;
      iss_valid_q <= 1'b0;
      for (int i = 0; i < int'(N); i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++)
        for (int k = 0; k < int'(K); k++)
          if (wake_set[i][k]) opr_q[i][k] <= 1'b1;
      if (issue_fire) begin
        valid_q[sel_idx] <= 1'b0;
        iss_valid_q      <= 1'b1;
        iss_id_q         <= id_q[sel_idx];
        iss_inst_q       <= inst_q[sel_idx];
        iss_pc_q         <= pc_q[sel_idx];
        iss_outprn_q     <= outprn_q[sel_idx];
        for (int k = 0; k < int'(K); k++)
          iss_op_q[k*64 +: 64] <= opv_q[sel_idx][k] ? bus.prf_op[k*64 +: 64] : 64'd0;
      end else if (bus.iss_ready) begin
        iss_valid_q <= 1'b0;
      end
      if (insert) begin
        valid_q[free_idx]  <= 1'b1;
        id_q[free_idx]     <= bus.in_inst_id;
        inst_q[free_idx]   <= bus.in_inst;
        pc_q[free_idx]     <= bus.in_pc;
        opv_q[free_idx]    <= bus.in_op_valid;
        opr_q[free_idx]    <= bus.in_op_ready | in_wake;
        prn_q[free_idx]    <= bus.in_op_prn;
        outprn_q[free_idx] <= bus.in_out_prn;
        older_q[free_idx]  <= '0;
        for (int j = 0; j < int'(N); j++) older_q[j][free_idx] <= valid_q[j];
      end
      occ_q <= occ_q + OCC_W'(insert) - OCC_W'(issue_fire);
    end
  end

  always @(posedge clk) begin
    if (!rst) assert (occ_q <= OCC_W'(N)) else $error("iq%0d: occupancy overflow", FU_INDEX);
  end

`ifdef IQ_STATS_EN
  logic [31:0] stat_issued_q;
  logic [31:0] stat_full_stall_q;

  // Saturating counters survive flush; only reset clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued_q     <= '0;
      stat_full_stall_q <= '0;
    end else begin
      if (iss_valid_q && bus.iss_ready && (stat_issued_q != '1))
        stat_issued_q <= stat_issued_q + 32'd1;
      if (bus.in_valid && !bus.in_ready && (stat_full_stall_q != '1))
        stat_full_stall_q <= stat_full_stall_q + 32'd1;
    end
  end

  assign bus.stat_issued     = stat_issued_q;
  assign bus.stat_full_stall = stat_full_stall_q;
`endif
endmodule
